up_control_unit: RTL and testbench
==================================

# up_control_unit

Parametrised control unit for the accumulator microprocessor. It is the successor to the 3-bit-opcode controller. It runs the START/FETCH/DECODE/execute sequence and decodes an OPW-bit opcode into datapath control strobes. Beyond the earlier controller, it adds unconditional and negative/non-zero jumps, an OUTPUT instruction, NOP, sticky illegal-opcode trapping, an optional memory-ready handshake, and a retired-instruction counter. It sits between the instruction register/status flags and the datapath (PC, IR, A register, ALU, memory).

## Interface
- OPW, 4, opcode width; legal values 3 or 4. Opcode is the top OPW bits of the instruction register.
- CNT_W, 16, retired-instruction counter width.
- CLOCK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IR  in  OPW  opcode field of the instruction register.
- Aeq0  in  1  A == 0.
- Apos  in  1  A sign bit clear (zero counts as positive).
- Enter  in  1  operator input-valid level.
- MemRdy  in  1  memory access complete (used only with UP_CU_MEMWAIT_EN).
- IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Outload  out  1 each  datapath strobes.
- Asel  out  2  A input select: 00 ALU, 01 input port, 10 memory.
- Illegal  out  1  high while trapped on an illegal opcode.
- Retire  out  1  one-cycle pulse per completed instruction.
- InstrCount  out  CNT_W  retired-instruction count.

## Operation
- States (5-bit encoding): START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT, JMP, JNZ, JNEG, OUTPUT, NOP, ILLEGAL.
- The sequence is START -> FETCH -> DECODE -> execute state -> START.
- Opcode map: 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 INPUT, 5 JZ, 6 JPOS, 7 HALT (identical to the 3-bit controller), 8 JMP, 9 JNZ, 10 JNEG, 11 OUTPUT, 12 NOP, 13–15 ILLEGAL.
- With OPW=3, only opcodes 0–7 exist and ILLEGAL is unreachable.
- Strobes are decoded combinationally from state. Any strobe not listed for a state is 0; Asel defaults to 00.
  - START: none.
  - FETCH: IRload=1, PCload=1.
  - DECODE: Meminst=1.
  - LOAD: Meminst=1, Aload=1, Asel=10.
  - STORE: Meminst=1, MemWr=1.
  - ADD: Meminst=1, Aload=1.
  - SUB: Meminst=1, Aload=1, Sub=1.
  - INPUT: Asel=01, Aload=Enter. The state stays in INPUT while Enter=0 and goes to START when Enter=1.
  - JZ: JMPmux=1, PCload=Aeq0.
  - JPOS: JMPmux=1, PCload=Apos&~Aeq0.
  - JMP: JMPmux=1, PCload=1.
  - JNZ: JMPmux=1, PCload=~Aeq0.
  - JNEG: JMPmux=1, PCload=~Apos.
  - OUTPUT: Outload=1.
  - NOP: none.
  - HALT: Halt=1; self-loops.
  - ILLEGAL: Halt=1, Illegal=1; self-loops.
- HALT and ILLEGAL are left only by RESET.
- Retire=1 in any cycle where the state is an execute state other than HALT/ILLEGAL and the next state is START.
- InstrCount increments by 1 on each Retire and wraps from 2^CNT_W−1 to 0.
- Undefined state encodings go to START on the next edge with all strobes 0.

## Timing
- RESET is sampled on the CLOCK rising edge.
  - After that edge: state=START, InstrCount=0.
  - All outputs are 0, including MemWr, Illegal and Retire.
- RESET overrides every transition, including mid-STORE, mid-INPUT and trap states.
- Minimum instruction time is 4 cycles (START, FETCH, DECODE, execute). Retire is asserted in the 4th cycle.
- INPUT adds one cycle per cycle that Enter is low. Aload and Retire coincide with the Enter=1 cycle.
- Jump decisions use Aeq0/Apos as sampled in the execute cycle.
- The A register is written in the execute cycle, so a flag change caused by it is visible to the next instruction.

## Configuration
- Macro: UP_CU_MEMWAIT_EN.
- Defined:
  - FETCH, LOAD, STORE, ADD and SUB hold until MemRdy=1.
  - In FETCH, IRload and PCload are asserted only when MemRdy=1.
  - In LOAD, ADD and SUB, Aload is asserted only when MemRdy=1.
  - STORE holds MemWr=1 every cycle until it exits on MemRdy=1.
  - Each wait cycle extends the instruction by one cycle.
- Undefined: MemRdy is ignored (treated as 1), and every memory state lasts exactly one cycle.

## Test plan
- RESET held 2 cycles during STORE -> MemWr=0 after the first reset edge; state START; InstrCount=0; all outputs 0.
- Program LOAD, ADD, SUB, STORE, NOP, HALT (opcodes 0,2,3,1,12,7) with MemRdy=1 -> each takes 4 cycles; strobes as listed; InstrCount=5; Halt stays 1 for 20 further cycles.
- Jump sweep: JZ/JNZ/JPOS/JNEG/JMP with (Aeq0,Apos) = (1,1), (0,1), (0,0) -> PCload =
  - JZ: 1,0,0
  - JNZ: 0,1,1
  - JPOS: 0,1,0
  - JNEG: 0,0,1
  - JMP: 1,1,1
  - JMPmux=1 in all cases.
- INPUT with Enter low 3 cycles then high -> 3 cycles in INPUT with Aload=0 and Asel=01, then Aload=1 and Retire=1 for one cycle -> START.
- Opcode 13 (OPW=4) -> ILLEGAL; Illegal=1 and Halt=1 held; InstrCount unchanged; RESET clears the trap.
- UP_CU_MEMWAIT_EN defined, MemRdy low 2 cycles in FETCH and STORE -> each state lasts 3 cycles; IRload/PCload only in the 3rd FETCH cycle; MemWr high for all 3 STORE cycles. Separately, CNT_W=4 with 16 NOPs -> InstrCount wraps to 0.

Source files
------------

// File: rtl/up_control_unit_if.sv
// rtl/up_control_unit_if.sv - status/strobe bundle between up_control_unit and the datapath
//
// Parameters: OPW   opcode width (3 or 4)
//             CNT_W retired-instruction counter width
// master : control-unit side; samples IR, Aeq0, Apos, Enter, MemRdy and drives
//          IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Outload,
//          Asel, Illegal, Retire, InstrCount.
// slave  : datapath side; the mirror image of master.
interface up_control_unit_if #(
   parameter int OPW   = 4,
   parameter int CNT_W = 16
);
   logic [OPW-1:0]   IR;
   logic             Aeq0;
   logic             Apos;
   logic             Enter;
   logic             MemRdy;
   logic             IRload;
   logic             JMPmux;
   logic             PCload;
   logic             Meminst;
   logic             MemWr;
   logic             Aload;
   logic             Sub;
   logic             Halt;
   logic             Outload;
   logic [1:0]       Asel;
   logic             Illegal;
   logic             Retire;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      input  IR, Aeq0, Apos, Enter, MemRdy,
      output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Outload,
      output Asel, Illegal, Retire, InstrCount
   );

   modport slave (
      output IR, Aeq0, Apos, Enter, MemRdy,
      input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Outload,
      input  Asel, Illegal, Retire, InstrCount
   );
endinterface

// File: rtl/up_control_unit.sv
// rtl/up_control_unit.sv - accumulator CPU controller: START/FETCH/DECODE/execute sequencer
//
// Ports:  CLOCK   rising-edge clock
//         RESET   synchronous, active-high
//         io_bus  up_control_unit_if.master (opcode, flags, Enter, MemRdy in;
//                 datapath strobes, Asel, Illegal, Retire, InstrCount out)
// Optional feature: define UP_CU_MEMWAIT_EN to make FETCH/LOAD/STORE/ADD/SUB
// wait for MemRdy; otherwise MemRdy is ignored and memory states last one cycle.
module up_control_unit #(
   parameter int OPW   = 4,
   parameter int CNT_W = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   up_control_unit_if.master io_bus
);

   typedef enum logic [4:0] {
      S_START   = 5'd0,
      S_FETCH   = 5'd1,
      S_DECODE  = 5'd2,
      S_LOAD    = 5'd3,
      S_STORE   = 5'd4,
      S_ADD     = 5'd5,
      S_SUB     = 5'd6,
      S_INPUT   = 5'd7,
      S_JZ      = 5'd8,
      S_JPOS    = 5'd9,
      S_HALT    = 5'd10,
      S_JMP     = 5'd11,
      S_JNZ     = 5'd12,
      S_JNEG    = 5'd13,
      S_OUTPUT  = 5'd14,
      S_NOP     = 5'd15,
      S_ILLEGAL = 5'd16
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;

   logic [OPW-1:0]   w_ir;
   logic [3:0]       w_op;
   logic             w_mem_rdy;
   logic             w_exec;
   logic             w_retire;
   logic             w_irload, w_jmpmux, w_pcload, w_meminst, w_memwr;
   logic             w_aload, w_sub, w_halt, w_outload, w_illegal;
   logic [1:0]       w_asel;

   // A 3-bit opcode zero-extends onto the low half of the map, so ILLEGAL
   // cannot be reached when OPW=3.
   assign w_ir = io_bus.IR;
   assign w_op = 4'(w_ir);

`ifdef UP_CU_MEMWAIT_EN
   assign w_mem_rdy = io_bus.MemRdy;
`else
   logic w_unused_memrdy;
   assign w_unused_memrdy = io_bus.MemRdy;
   assign w_mem_rdy       = 1'b1;
`endif

   always_comb begin
      w_next    = S_START;
      w_exec    = 1'b0;
      w_irload  = 1'b0;
      w_jmpmux  = 1'b0;
      w_pcload  = 1'b0;
      w_meminst = 1'b0;
      w_memwr   = 1'b0;
      w_aload   = 1'b0;
      w_sub     = 1'b0;
      w_halt    = 1'b0;
      w_outload = 1'b0;
      w_illegal = 1'b0;
      w_asel    = 2'b00;
      case (r_state)
         S_START: w_next = S_FETCH;
         S_FETCH: begin
            w_irload = w_mem_rdy;
            w_pcload = w_mem_rdy;
            w_next   = w_mem_rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            w_meminst = 1'b1;
            case (w_op)
               4'd0:    w_next = S_LOAD;
               4'd1:    w_next = S_STORE;
               4'd2:    w_next = S_ADD;
               4'd3:    w_next = S_SUB;
               4'd4:    w_next = S_INPUT;
               4'd5:    w_next = S_JZ;
               4'd6:    w_next = S_JPOS;
               4'd7:    w_next = S_HALT;
               4'd8:    w_next = S_JMP;
               4'd9:    w_next = S_JNZ;
               4'd10:   w_next = S_JNEG;
               4'd11:   w_next = S_OUTPUT;
               4'd12:   w_next = S_NOP;
               default: w_next = S_ILLEGAL;
            endcase
         end
         S_LOAD: begin
            w_exec    = 1'b1;
            w_meminst = 1'b1;
            w_aload   = w_mem_rdy;
            w_asel    = 2'b10;
            w_next    = w_mem_rdy ? S_START : S_LOAD;
         end
         S_STORE: begin
            // MemWr stays up for the whole wait so the memory sees a stable write.
            w_exec    = 1'b1;
            w_meminst = 1'b1;
            w_memwr   = 1'b1;
            w_next    = w_mem_rdy ? S_START : S_STORE;
         end
         S_ADD: begin
            w_exec    = 1'b1;
            w_meminst = 1'b1;
            w_aload   = w_mem_rdy;
            w_next    = w_mem_rdy ? S_START : S_ADD;
         end
         S_SUB: begin
            w_exec    = 1'b1;
            w_meminst = 1'b1;
            w_aload   = w_mem_rdy;
            w_sub     = 1'b1;
            w_next    = w_mem_rdy ? S_START : S_SUB;
         end
         S_INPUT: begin
            w_exec  = 1'b1;
            w_asel  = 2'b01;
            w_aload = io_bus.Enter;
            w_next  = io_bus.Enter ? S_START : S_INPUT;
         end
         S_JZ: begin
            w_exec   = 1'b1;
            w_jmpmux = 1'b1;
            w_pcload = io_bus.Aeq0;
         end
         S_JPOS: begin
            // Zero counts as positive on Apos, so exclude it explicitly.
            w_exec   = 1'b1;
            w_jmpmux = 1'b1;
            w_pcload = io_bus.Apos & ~io_bus.Aeq0;
         end
         S_JMP: begin
            w_exec   = 1'b1;
            w_jmpmux = 1'b1;
            w_pcload = 1'b1;
         end
         S_JNZ: begin
            w_exec   = 1'b1;
            w_jmpmux = 1'b1;
            w_pcload = ~io_bus.Aeq0;
         end
         S_JNEG: begin
            w_exec   = 1'b1;
            w_jmpmux = 1'b1;
            w_pcload = ~io_bus.Apos;
         end
         S_OUTPUT: begin
            w_exec    = 1'b1;
            w_outload = 1'b1;
         end
         S_NOP: w_exec = 1'b1;
         S_HALT: begin
            w_halt = 1'b1;
            w_next = S_HALT;
         end
         S_ILLEGAL: begin
            w_halt    = 1'b1;
            w_illegal = 1'b1;
            w_next    = S_ILLEGAL;
         end
         default: w_next = S_START;
      endcase
   end

   // HALT/ILLEGAL never flag w_exec, so trapped states cannot retire.
   assign w_retire = w_exec && (w_next == S_START);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state <= S_START;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign io_bus.IRload     = w_irload;
   assign io_bus.JMPmux     = w_jmpmux;
   assign io_bus.PCload     = w_pcload;
   assign io_bus.Meminst    = w_meminst;
   assign io_bus.MemWr      = w_memwr;
   assign io_bus.Aload      = w_aload;
   assign io_bus.Sub        = w_sub;
   assign io_bus.Halt       = w_halt;
   assign io_bus.Outload    = w_outload;
   assign io_bus.Asel       = w_asel;
   assign io_bus.Illegal    = w_illegal;
   assign io_bus.Retire     = w_retire;
   assign io_bus.InstrCount = r_count;

endmodule

// File: tb/tb_up_control_unit.sv
// tb/tb_up_control_unit.sv - self-checking bench for up_control_unit
module tb_up_control_unit;

   // Observed vector: {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Halt,Outload,Asel[1:0],Illegal,Retire}
   localparam logic [12:0] IRL = 13'h1000, JMX = 13'h0800, PCL = 13'h0400, MEI = 13'h0200;
   localparam logic [12:0] MWR = 13'h0100, ALD = 13'h0080, SUB = 13'h0040, HLT = 13'h0020;
   localparam logic [12:0] OUT = 13'h0010, ASM = 13'h0008, ASI = 13'h0004, ILL = 13'h0002;
   localparam logic [12:0] RET = 13'h0001, NONE = 13'h0000;

   typedef struct {
      logic [3:0]  op;
      logic        z;
      logic        p;
      logic [12:0] exp_x;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic rst_w;
   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt  = 0;

   always #5 clk = ~clk;

   up_control_unit_if #(.OPW(4), .CNT_W(16)) bus ();
   up_control_unit_if #(.OPW(4), .CNT_W(4))  bus_w ();

   up_control_unit #(.OPW(4), .CNT_W(16)) dut (.CLOCK(clk), .RESET(rst), .io_bus(bus));
   up_control_unit #(.OPW(4), .CNT_W(4))  dut_w (.CLOCK(clk), .RESET(rst_w), .io_bus(bus_w));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [12:0] obs();
      return {bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr, bus.Aload,
              bus.Sub, bus.Halt, bus.Outload, bus.Asel, bus.Illegal, bus.Retire};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // MemRdy must be 1 when waits are enabled; otherwise it is noise the DUT must ignore.
   function automatic logic rdy_rand();
`ifdef UP_CU_MEMWAIT_EN
      return 1'b1;
`else
      return rb();
`endif
   endfunction

   // Expected execute-cycle strobes straight from the instruction list (opcode view).
   function automatic logic [12:0] exp_exec(input logic [3:0] op, input logic z, input logic p);
      case (op)
         4'd0:    return MEI | ALD | ASM | RET;
         4'd1:    return MEI | MWR | RET;
         4'd2:    return MEI | ALD | RET;
         4'd3:    return MEI | ALD | SUB | RET;
         4'd5:    return JMX | (z ? PCL : NONE) | RET;
         4'd6:    return JMX | ((p && !z) ? PCL : NONE) | RET;
         4'd8:    return JMX | PCL | RET;
         4'd9:    return JMX | (!z ? PCL : NONE) | RET;
         4'd10:   return JMX | (!p ? PCL : NONE) | RET;
         4'd11:   return OUT | RET;
         4'd12:   return RET;
         default: return HLT;
      endcase
   endfunction

   function automatic logic [31:0] cnt16();
      return 32'(exp_cnt) & 32'hFFFF;
   endfunction

   // START, FETCH, DECODE; returns one cycle into the execute state.
   task automatic front(input logic [3:0] op, input string nm);
      bus.IR = op; bus.Aeq0 = rb(); bus.Apos = rb(); bus.Enter = rb(); bus.MemRdy = rdy_rand();
      #1;
      check({nm, ":start"}, 32'(obs()), 32'(NONE));
      check({nm, ":count"}, 32'(bus.InstrCount), cnt16());
      tick();
      bus.Aeq0 = rb(); bus.Apos = rb(); bus.MemRdy = rdy_rand();
      #1;
      check({nm, ":fetch"}, 32'(obs()), 32'(IRL | PCL));
      tick();
      bus.Aeq0 = rb(); bus.Apos = rb(); bus.MemRdy = rdy_rand();
      #1;
      check({nm, ":decode"}, 32'(obs()), 32'(MEI));
      tick();
   endtask

   task automatic do_instr(input logic [3:0] op, input logic z, input logic p,
                           input logic [12:0] exp_x, input string nm);
      front(op, nm);
      bus.Aeq0 = z; bus.Apos = p; bus.Enter = rb(); bus.MemRdy = rdy_rand();
      #1;
      check({nm, ":exec"}, 32'(obs()), 32'(exp_x));
      if ((exp_x & RET) != NONE) exp_cnt++;
      tick();
   endtask

   task automatic input_instr(input int k, input string nm);
      front(4'd4, nm);
      for (int i = 0; i < k; i++) begin
         bus.Enter = 1'b0; bus.Aeq0 = rb(); bus.Apos = rb();
         #1;
         check({nm, ":wait"}, 32'(obs()), 32'(ASI));
         tick();
      end
      bus.Enter = 1'b1;
      #1;
      check({nm, ":enter"}, 32'(obs()), 32'(ASI | ALD | RET));
      exp_cnt++;
      tick();
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      tick();
      check({nm, ":outs"}, 32'(obs()), 32'(NONE));
      check({nm, ":count"}, 32'(bus.InstrCount), 32'd0);
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   vec_t       tbl [20];
   logic [3:0] jop [5];
   logic [2:0] jpc [5];
   logic       zf  [3];
   logic       pf  [3];
   logic [3:0] legal_ops [12];

   initial begin
      tbl[0] = '{4'd0,  1'b0, 1'b1, MEI | ALD | ASM | RET};
      tbl[1] = '{4'd2,  1'b0, 1'b1, MEI | ALD | RET};
      tbl[2] = '{4'd3,  1'b0, 1'b1, MEI | ALD | SUB | RET};
      tbl[3] = '{4'd1,  1'b0, 1'b1, MEI | MWR | RET};
      tbl[4] = '{4'd12, 1'b0, 1'b1, RET};
      // PCload for (Aeq0,Apos) = (1,1),(0,1),(0,0), MSB first
      jop = '{4'd5, 4'd9, 4'd6, 4'd10, 4'd8};
      jpc = '{3'b100, 3'b011, 3'b010, 3'b001, 3'b111};
      zf  = '{1'b1, 1'b0, 1'b0};
      pf  = '{1'b1, 1'b1, 1'b0};
      for (int j = 0; j < 5; j++)
         for (int k = 0; k < 3; k++)
            tbl[5 + 3*j + k] = '{jop[j], zf[k], pf[k], JMX | (jpc[j][2-k] ? PCL : NONE) | RET};
      legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

      bus.IR = 4'd0; bus.Aeq0 = 1'b0; bus.Apos = 1'b0; bus.Enter = 1'b0; bus.MemRdy = 1'b1;
      bus_w.IR = 4'd12; bus_w.Aeq0 = 1'b0; bus_w.Apos = 1'b0; bus_w.Enter = 1'b0; bus_w.MemRdy = 1'b1;
      rst = 1'b1; rst_w = 1'b1;
      tick();
      do_reset("reset_init");

      // Program LOAD, ADD, SUB, STORE, NOP followed by the jump sweep
      for (int i = 0; i < 20; i++)
         do_instr(tbl[i].op, tbl[i].z, tbl[i].p, tbl[i].exp_x, $sformatf("vec%0d_op%0d", i, tbl[i].op));

      // HALT holds for 20 further cycles without retiring
      front(4'd7, "halt");
      for (int i = 0; i < 21; i++) begin
         bus.Enter = rb(); bus.Aeq0 = rb();
         #1;
         check("halt:hold", 32'(obs()), 32'(HLT));
         check("halt:count", 32'(bus.InstrCount), cnt16());
         tick();
      end
      do_reset("reset_halt");

      // Reset held two cycles in the middle of STORE
      do_instr(4'd12, 1'b0, 1'b1, RET, "nop_pre");
      front(4'd1, "rst_store");
      #1;
      check("rst_store:exec", 32'(obs()), 32'(MEI | MWR | RET));
      rst = 1'b1;
      tick();
      check("rst_store:outs1", 32'(obs()), 32'(NONE));
      check("rst_store:count1", 32'(bus.InstrCount), 32'd0);
      tick();
      check("rst_store:outs2", 32'(obs()), 32'(NONE));
      rst = 1'b0;
      exp_cnt = 0;

      // INPUT with Enter low for three cycles
      input_instr(3, "input3");
      do_instr(4'd12, 1'b0, 1'b1, RET, "nop_post_input");

      // Illegal opcode traps until reset
      front(4'd13, "illegal");
      for (int i = 0; i < 6; i++) begin
         #1;
         check("illegal:hold", 32'(obs()), 32'(HLT | ILL));
         check("illegal:count", 32'(bus.InstrCount), cnt16());
         tick();
      end
      do_reset("reset_illegal");

      // STORE with MemRdy low for the first two FETCH and STORE cycles
      bus.IR = 4'd1; bus.MemRdy = 1'b1;
      #1;
      check("mw:start", 32'(obs()), 32'(NONE));
      tick();
`ifdef UP_CU_MEMWAIT_EN
      for (int i = 0; i < 3; i++) begin
         bus.MemRdy = (i == 2);
         #1;
         check("mw:fetch", 32'(obs()), 32'((i == 2) ? (IRL | PCL) : NONE));
         tick();
      end
      bus.MemRdy = 1'b0;
      #1;
      check("mw:decode", 32'(obs()), 32'(MEI));
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.MemRdy = (i == 2);
         #1;
         check("mw:store", 32'(obs()), 32'(MEI | MWR | ((i == 2) ? RET : NONE)));
         tick();
      end
`else
      bus.MemRdy = 1'b0;
      #1;
      check("mw:fetch", 32'(obs()), 32'(IRL | PCL));
      tick();
      #1;
      check("mw:decode", 32'(obs()), 32'(MEI));
      tick();
      #1;
      check("mw:store", 32'(obs()), 32'(MEI | MWR | RET));
      tick();
`endif
      exp_cnt++;
      bus.MemRdy = 1'b1;
      #1;
      check("mw:after", 32'(obs()), 32'(NONE));
      check("mw:count", 32'(bus.InstrCount), cnt16());

      // Randomised instruction stream against the opcode-level model
      for (int n = 0; n < 80; n++) begin
         logic [3:0] op;
         logic       z, p;
         op = legal_ops[$urandom_range(0, 11)];
         z  = rb();
         p  = z ? 1'b1 : rb();
         if (op == 4'd4) input_instr(int'($urandom_range(0, 3)), $sformatf("rnd%0d_input", n));
         else            do_instr(op, z, p, exp_exec(op, z, p), $sformatf("rnd%0d_op%0d", n, op));
      end
      #1;
      check("rnd:final_count", 32'(bus.InstrCount), cnt16());

      // 4-bit counter wraps after 16 NOPs
      rst_w = 1'b1;
      tick();
      rst_w = 1'b0;
      check("wrap:reset", 32'(bus_w.InstrCount), 32'd0);
      repeat (60) tick();
      check("wrap:15", 32'(bus_w.InstrCount), 32'd15);
      repeat (4) tick();
      check("wrap:0", 32'(bus_w.InstrCount), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
